// File: rtl/notas.sv
// notas: registered note-code to 7-segment letter decoder.
// Define NOTAS_ACTIVE_LOW_EN for a common-anode (0 = lit) display.
module notas (
    input  logic clock,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5,
    output logic s6
);

    // Segment patterns, {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_G     = 7'b0111101;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

`ifdef NOTAS_ACTIVE_LOW_EN
    localparam logic [6:0] POL_MASK = 7'b1111111;
`else
    localparam logic [6:0] POL_MASK = 7'b0000000;
`endif

    // Blank at the display pins, whichever polarity is built
    localparam logic [6:0] OUT_BLANK = SEG_BLANK ^ POL_MASK;

    logic [3:0] code;
    logic [6:0] seg_nxt;
    logic [6:0] seg_q;

    assign code = {a, b, c, d};

    // Note code to active-high pattern; anything unmatched
    // (unused codes, or X/Z in simulation) falls to blank
    always_comb begin
        seg_nxt = SEG_BLANK;
        case (code)
            4'd0:    seg_nxt = SEG_C;
            4'd1:    seg_nxt = SEG_D;
            4'd2:    seg_nxt = SEG_E;
            4'd3:    seg_nxt = SEG_F;
            4'd4:    seg_nxt = SEG_G;
            4'd5:    seg_nxt = SEG_A;
            4'd6:    seg_nxt = SEG_B;
            4'd7:    seg_nxt = SEG_BLANK;
            4'd8:    seg_nxt = SEG_BLANK;
            4'd9:    seg_nxt = SEG_BLANK;
            4'd10:   seg_nxt = SEG_BLANK;
            4'd11:   seg_nxt = SEG_BLANK;
            4'd12:   seg_nxt = SEG_BLANK;
            4'd13:   seg_nxt = SEG_BLANK;
            4'd14:   seg_nxt = SEG_BLANK;
            4'd15:   seg_nxt = SEG_DASH;
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // Single output register; polarity applied before the flop
    // so the pins are driven glitch-free straight from flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= OUT_BLANK;
        end else begin
            seg_q <= seg_nxt ^ POL_MASK;
        end
    end

    assign s0 = seg_q[0];
    assign s1 = seg_q[1];
    assign s2 = seg_q[2];
    assign s3 = seg_q[3];
    assign s4 = seg_q[4];
    assign s5 = seg_q[5];
    assign s6 = seg_q[6];

endmodule

// File: tb/tb_notas.sv
// tb_notas: directed bench for the notas segment decoder.
// Expected patterns are active-high; flipped when NOTAS_ACTIVE_LOW_EN is set.
module tb_notas;

    logic clock;
    logic reset;
    logic a, b, c, d;
    logic s0, s1, s2, s3, s4, s5, s6;

    int compared;
    int mismatched;

`ifdef NOTAS_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'b1111111;
`else
    localparam logic [6:0] INV = 7'b0000000;
`endif

    logic [6:0] exp_tab [16];

    notas dut (
        .clock(clock),
        .reset(reset),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .s0(s0),
        .s1(s1),
        .s2(s2),
        .s3(s3),
        .s4(s4),
        .s5(s5),
        .s6(s6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_code(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp_hi);
        logic [6:0] obs;
        logic [6:0] expv;
        obs = {s6, s5, s4, s3, s2, s1, s0};
        expv = exp_hi ^ INV;
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        exp_tab[0]  = 7'b0111001;
        exp_tab[1]  = 7'b1011110;
        exp_tab[2]  = 7'b1111001;
        exp_tab[3]  = 7'b1110001;
        exp_tab[4]  = 7'b0111101;
        exp_tab[5]  = 7'b1110111;
        exp_tab[6]  = 7'b1111100;
        for (int i = 7; i < 15; i++) exp_tab[i] = 7'b0000000;
        exp_tab[15] = 7'b1000000;

        // Reset held low with code 0: outputs stay blank
        reset = 1'b1;
        set_code(4'b0000);
        #2 reset = 1'b0;
        #1 chk("reset_async", 7'b0000000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1 chk("reset_hold", 7'b0000000);
        end

        // Release between edges, first decode on next edge
        @(negedge clock);
        reset = 1'b1;
        #1 chk("release_no_edge", 7'b0000000);
        @(posedge clock);
        #1 chk("first_decode", 7'b0111001);

        // Sweep all codes
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            set_code(4'(i));
            @(posedge clock);
            #1 chk($sformatf("sweep_%0d", i), exp_tab[i]);
        end

        // Latency: change just after an edge
        @(negedge clock);
        set_code(4'b0010);
        @(posedge clock);
        #1 chk("lat_mi", 7'b1111001);
        set_code(4'b0101);
        #2 chk("lat_hold", 7'b1111001);
        @(negedge clock);
        chk("lat_hold_neg", 7'b1111001);
        @(posedge clock);
        #1 chk("lat_la", 7'b1110111);

        // Async reset mid-stream
        @(negedge clock);
        set_code(4'b0110);
        @(posedge clock);
        #1 chk("pre_rst_si", 7'b1111100);
        #2 reset = 1'b0;
        #1 chk("mid_rst_blank", 7'b0000000);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("mid_rst_release", 7'b0000000);
        @(posedge clock);
        #1 chk("post_rst_si", 7'b1111100);

        // Hold a constant code for 10 cycles
        @(negedge clock);
        set_code(4'b0100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1 chk($sformatf("hold_pos_%0d", i), 7'b0111101);
            @(negedge clock);
            chk($sformatf("hold_neg_%0d", i), 7'b0111101);
        end

        // Fa then reset again, as the optional-feature check
        set_code(4'b0011);
        @(posedge clock);
        #1 chk("fa", 7'b1110001);
        reset = 1'b0;
        #1 chk("final_rst", 7'b0000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
